// File: rtl/pe_mac_param.sv
// pe_mac_param: systolic PE with operand FIFOs, neighbour forwarding and a pipelined saturating MAC
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start / start_next    clear+arm (samples acc_len, sgn) / start delayed one cycle
//   acc_len, sgn          terms per result minus 1, signed mode
//   hold                  array-level stall of pops and MAC pipeline
//   a_we,a_in,a_ff        A FIFO push, data, full
//   b_we,b_in,b_ff        B FIFO push, data, full
//   a_out,b_out,fwd_v     last consumed pair to neighbours, 1-cycle update pulse
//   s_out,s_sat,s_valid,s_ready  result, saturation flag, valid/ready handshake
//   busy                  terms pending in FIFOs or pipeline
module pe_mac_param #(
    parameter int DW    = 16,
    parameter int ACCW  = 40,
    parameter int OW    = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 8,
    parameter int SHIFT = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          start_next,
    input  logic [CW-1:0] acc_len,
    input  logic          sgn,
    input  logic          hold,
    input  logic          a_we,
    input  logic          b_we,
    input  logic [DW-1:0] a_in,
    input  logic [DW-1:0] b_in,
    output logic          a_ff,
    output logic          b_ff,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic          fwd_v,
    output logic [OW-1:0] s_out,
    output logic          s_valid,
    input  logic          s_ready,
    output logic          s_sat,
    output logic          busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DW-1:0]     r_a_mem [DEPTH];
    logic [DW-1:0]     r_b_mem [DEPTH];
    logic [AW-1:0]     r_a_wp, r_a_rp, r_b_wp, r_b_rp;
    logic [AW:0]       r_a_cnt, r_b_cnt;
    logic              r_sgn;
    logic [CW-1:0]     r_len, r_cnt;
    logic [2*DW-1:0]   r_prod;
    logic              r_p_v, r_p_last;
    logic [ACCW-1:0]   r_acc;
    logic              r_acc_last, r_mid, r_sticky;

    logic              w_adv, w_pop, w_a_push, w_b_push;
    logic [DW-1:0]     w_a_hd, w_b_hd;
    logic signed [2*DW-1:0] w_prod_s;
    logic [2*DW-1:0]   w_prod_u, w_prod;
    logic [ACCW-1:0]   w_pe_s, w_pe_u, w_pe, w_clamp;
    logic [ACCW:0]     w_sum;
    logic              w_ovf;
    logic [ACCW-1:0]   w_shs, w_shu, w_sh;
    logic              w_oclamp;
    logic [OW-1:0]     w_oval;

    assign a_ff     = r_a_cnt == FULL;
    assign b_ff     = r_b_cnt == FULL;
    assign w_adv    = ~hold & ~(s_valid & ~s_ready);
    assign w_pop    = w_adv & (r_a_cnt != '0) & (r_b_cnt != '0);
    // a full FIFO refuses pushes even if it pops this cycle; start drops pushes
    assign w_a_push = a_we & ~a_ff & ~start;
    assign w_b_push = b_we & ~b_ff & ~start;
    assign w_a_hd   = r_a_mem[r_a_rp];
    assign w_b_hd   = r_b_mem[r_b_rp];
    assign busy     = (r_a_cnt != '0) | (r_b_cnt != '0) | r_p_v | r_acc_last | r_mid;

    // signed and unsigned products kept separate so neither extends the other
    assign w_prod_s = $signed(w_a_hd) * $signed(w_b_hd);
    assign w_prod_u = w_a_hd * w_b_hd;
    assign w_prod   = r_sgn ? w_prod_s : w_prod_u;

    assign w_pe_s   = ACCW'($signed(r_prod));
    assign w_pe_u   = ACCW'(r_prod);
    assign w_pe     = r_sgn ? w_pe_s : w_pe_u;

    // one guard bit: true sign in signed mode, carry in unsigned mode
    assign w_sum    = {r_sgn & r_acc[ACCW-1], r_acc} + {r_sgn & w_pe[ACCW-1], w_pe};
    assign w_ovf    = r_sgn ? (w_sum[ACCW] != w_sum[ACCW-1]) : w_sum[ACCW];
    assign w_clamp  = ~r_sgn ? '1 : w_sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};

    assign w_shs    = $signed(r_acc) >>> SHIFT;
    assign w_shu    = r_acc >> SHIFT;
    assign w_sh     = r_sgn ? w_shs : w_shu;

    // signed fits when every bit from OW-1 upward equals the sign
    assign w_oclamp = r_sgn ? ~(&w_sh[ACCW-1:OW-1] | ~|w_sh[ACCW-1:OW-1]) : |w_sh[ACCW-1:OW];
    assign w_oval   = ~w_oclamp ? w_sh[OW-1:0] :
                      ~r_sgn ? '1 :
                      w_sh[ACCW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};

    always_ff @(posedge clk) begin
        if (w_a_push) r_a_mem[r_a_wp] <= a_in;
        if (w_b_push) r_b_mem[r_b_wp] <= b_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_next <= 1'b0;
            r_a_wp     <= '0;
            r_a_rp     <= '0;
            r_b_wp     <= '0;
            r_b_rp     <= '0;
            r_a_cnt    <= '0;
            r_b_cnt    <= '0;
            r_sgn      <= 1'b0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_prod     <= '0;
            r_p_v      <= 1'b0;
            r_p_last   <= 1'b0;
            r_acc      <= '0;
            r_acc_last <= 1'b0;
            r_mid      <= 1'b0;
            r_sticky   <= 1'b0;
            a_out      <= '0;
            b_out      <= '0;
            fwd_v      <= 1'b0;
            s_out      <= '0;
            s_sat      <= 1'b0;
            s_valid    <= 1'b0;
        end else begin
            start_next <= start;
            if (start) begin
                r_sgn      <= sgn;
                r_len      <= acc_len;
                r_cnt      <= acc_len;
                r_a_wp     <= '0;
                r_a_rp     <= '0;
                r_b_wp     <= '0;
                r_b_rp     <= '0;
                r_a_cnt    <= '0;
                r_b_cnt    <= '0;
                r_p_v      <= 1'b0;
                r_acc_last <= 1'b0;
                r_mid      <= 1'b0;
                r_sticky   <= 1'b0;
                fwd_v      <= 1'b0;
                s_valid    <= 1'b0;
            end else begin
                r_a_wp  <= r_a_wp + AW'(w_a_push);
                r_b_wp  <= r_b_wp + AW'(w_b_push);
                r_a_rp  <= r_a_rp + AW'(w_pop);
                r_b_rp  <= r_b_rp + AW'(w_pop);
                r_a_cnt <= r_a_cnt + (AW+1)'(w_a_push) - (AW+1)'(w_pop);
                r_b_cnt <= r_b_cnt + (AW+1)'(w_b_push) - (AW+1)'(w_pop);
                fwd_v   <= w_pop;
                if (w_pop) begin
                    a_out    <= w_a_hd;
                    b_out    <= w_b_hd;
                    r_prod   <= w_prod;
                    r_p_last <= r_cnt == '0;
                    r_cnt    <= r_cnt == '0 ? r_len : r_cnt - CW'(1);
                end
                if (w_adv) begin
                    r_p_v      <= w_pop;
                    r_acc_last <= r_p_v & r_p_last;
                    if (r_p_v) begin
                        r_acc    <= ~r_mid ? w_pe : w_ovf ? w_clamp : w_sum[ACCW-1:0];
                        r_sticky <= r_mid & (r_sticky | w_ovf);
                        r_mid    <= ~r_p_last;
                    end
                    if (r_acc_last) begin
                        s_out <= w_oval;
                        s_sat <= r_sticky | w_oclamp;
                    end
                end
                // a transfer frees the register; a finished result may refill it in the same cycle
                s_valid <= (w_adv & r_acc_last) | (s_valid & ~s_ready);
            end
        end
    end
endmodule

// File: tb/tb_pe_mac_param.sv
module tb_pe_mac_param;
    logic        clk = 0, rst_n = 0, start = 0, sgn = 0, hold = 0, a_we = 0, b_we = 0, s_ready = 1;
    logic [7:0]  acc_len = 0;
    logic [15:0] a_in = 0, b_in = 0;
    logic        start_next, a_ff, b_ff, fwd_v, s_valid, s_sat, busy;
    logic [15:0] a_out, b_out, s_out;

    pe_mac_param dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_next(start_next), .acc_len(acc_len),
        .sgn(sgn), .hold(hold), .a_we(a_we), .b_we(b_we), .a_in(a_in), .b_in(b_in),
        .a_ff(a_ff), .b_ff(b_ff), .a_out(a_out), .b_out(b_out), .fwd_v(fwd_v),
        .s_out(s_out), .s_valid(s_valid), .s_ready(s_ready), .s_sat(s_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            sgn;
        logic [7:0]      len;
        logic [2:0]      n;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [15:0]     eo;
        logic            es;
    } vec_t;

    vec_t        vt [11];
    logic [16:0] q [$];
    logic [16:0] e;
    int          checks = 0, failures = 0, cyc = 0, fwd_cnt = 0, last_fwd = 0, sv_rise = 0, sv_cycles = 0;
    logic        prev_stall = 0, prev_sv = 0, prev_sat = 0;
    logic [15:0] prev_out = 0;

    function automatic vec_t mk(logic s, logic [7:0] l, logic [2:0] n,
                                logic [15:0] a0, logic [15:0] a1, logic [15:0] a2, logic [15:0] a3,
                                logic [15:0] b0, logic [15:0] b1, logic [15:0] b2, logic [15:0] b3,
                                logic [15:0] eo, logic es);
        vec_t v;
        v.sgn = s; v.len = l; v.n = n;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
        v.eo = eo; v.es = es;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic s, input logic [7:0] l);
        start = 1; sgn = s; acc_len = l;
        tick;
        start = 0;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        a_in = a; b_in = b; a_we = 1; b_we = 1;
        tick;
        a_we = 0; b_we = 0;
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            tick;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: %0d results outstanding expected 0", name, q.size());
            q.delete();
        end
    endtask

    always @(posedge clk) cyc++;

    // scoreboard: every transfer pops one expected result; a held result must not move
    always @(negedge clk) begin
        if (rst_n) begin
            if (fwd_v) begin fwd_cnt++; last_fwd = cyc; end
            if (s_valid && !prev_sv) sv_rise = cyc;
            if (s_valid) sv_cycles++;
            if (prev_stall) begin
                chk("stall_valid", 32'(s_valid), 1);
                chk("stall_out", 32'(s_out), 32'(prev_out));
                chk("stall_sat", 32'(s_sat), 32'(prev_sat));
            end
            if (s_valid && s_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %0h expected none", s_out);
                end else begin
                    e = q.pop_front();
                    chk("s_out", 32'(s_out), 32'(e[15:0]));
                    chk("s_sat", 32'(s_sat), 32'(e[16]));
                end
            end
            prev_stall = s_valid & ~s_ready;
            prev_out = s_out;
            prev_sat = s_sat;
            prev_sv = s_valid;
        end
    end

    initial begin
        vt[0]  = mk(1, 2, 3, 1, 2, 3, 0, 4, 5, 16'hFFFA, 0, 16'hFFFC, 0);
        vt[1]  = mk(1, 3, 4, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1);
        vt[2]  = mk(1, 3, 4, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 1);
        vt[3]  = mk(0, 0, 1, 16'hFFFF, 0, 0, 0, 2, 0, 0, 0, 16'hFFFF, 1);
        vt[4]  = mk(0, 0, 1, 3, 0, 0, 0, 5, 0, 0, 0, 15, 0);
        vt[5]  = mk(1, 1, 2, 16'hFFFD, 16'hFFFC, 0, 0, 5, 2, 0, 0, 16'hFFE9, 0);
        vt[6]  = mk(0, 3, 4, 100, 200, 300, 400, 2, 2, 2, 2, 16'h07D0, 0);
        vt[7]  = mk(1, 0, 1, 16'h8000, 0, 0, 0, 16'h8000, 0, 0, 0, 16'h7FFF, 1);
        vt[8]  = mk(1, 1, 2, 16'h7FFF, 16'h8000, 0, 0, 1, 1, 0, 0, 16'hFFFF, 0);
        vt[9]  = mk(0, 1, 2, 16'h8000, 16'h8000, 0, 0, 1, 1, 0, 0, 16'hFFFF, 1);
        vt[10] = mk(1, 0, 1, 16'hFFFF, 0, 0, 0, 16'hFFFF, 0, 0, 0, 16'h0001, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_valid", 32'(s_valid), 0);
        chk("rst_s_out", 32'(s_out), 0);
        chk("rst_s_sat", 32'(s_sat), 0);
        chk("rst_fwd_v", 32'(fwd_v), 0);
        chk("rst_a_out", 32'(a_out), 0);
        chk("rst_a_ff", 32'(a_ff), 0);
        chk("rst_b_ff", 32'(b_ff), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start_next", 32'(start_next), 0);
        rst_n = 1;
        tick;

        foreach (vt[i]) begin
            do_start(vt[i].sgn, vt[i].len);
            chk("start_next", 32'(start_next), 1);
            sv_cycles = 0;
            q.push_back({vt[i].es, vt[i].eo});
            for (int k = 0; k < int'(vt[i].n); k++) push(vt[i].a[k], vt[i].b[k]);
            wait_drain("vec");
            repeat (4) tick;
            chk("fwd_a_out", 32'(a_out), 32'(vt[i].a[vt[i].n - 1]));
            chk("fwd_b_out", 32'(b_out), 32'(vt[i].b[vt[i].n - 1]));
            if (i == 0) begin
                chk("result_latency", 32'(sv_rise - last_fwd), 2);
                chk("valid_width", 32'(sv_cycles), 1);
            end
        end

        // backpressure: four pairs buffered, two more dropped on a full FIFO
        do_start(0, 0);
        s_ready = 0;
        hold = 1;
        for (int k = 0; k < 4; k++) q.push_back({1'b0, 16'(2 * (k + 1))});
        for (int k = 0; k < 6; k++) begin
            push(16'(k + 1), 2);
            if (k == 3) begin
                chk("a_ff_full", 32'(a_ff), 1);
                chk("b_ff_full", 32'(b_ff), 1);
            end
        end
        hold = 0;
        repeat (8) tick;
        chk("bp_held_valid", 32'(s_valid), 1);
        chk("bp_busy", 32'(busy), 1);
        s_ready = 1;
        repeat (4) tick;
        chk("bp_back_to_back", 32'(q.size()), 0);
        wait_drain("bp");
        repeat (6) tick;

        // hold for five cycles in the middle of a four-term product
        do_start(1, 3);
        fwd_cnt = 0;
        q.push_back({1'b0, 16'd8});
        push(1, 2);
        push(1, 2);
        hold = 1;
        push(1, 2);
        push(1, 2);
        tick;
        chk("hold_fwd_v", 32'(fwd_v), 0);
        repeat (2) tick;
        hold = 0;
        wait_drain("hold");
        repeat (6) tick;
        chk("hold_fwd_count", 32'(fwd_cnt), 4);

        // start with a partial sum in flight and two entries buffered
        do_start(0, 3);
        push(7, 9);
        push(7, 9);
        repeat (2) tick;
        hold = 1;
        push(5, 5);
        push(5, 5);
        chk("pre_start_busy", 32'(busy), 1);
        start = 1; sgn = 1; acc_len = 2;
        a_in = 3; b_in = 3; a_we = 1; b_we = 1;
        tick;
        start = 0; a_we = 0; b_we = 0; hold = 0;
        chk("post_start_busy", 32'(busy), 0);
        chk("post_start_valid", 32'(s_valid), 0);
        repeat (8) tick;
        chk("post_start_idle", 32'(busy), 0);
        q.push_back({1'b0, 16'hFFFC});
        push(1, 4);
        push(2, 5);
        push(3, 16'hFFFA);
        wait_drain("restart");
        repeat (6) tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
